// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops 32-bit words from a TX FIFO and sends them as four UART frames, byte 0 first
module uart_tx_serializer #(
  parameter int DIV_W     = 16,
  parameter int RESET_DIV = 1085
) (
  input  logic             clk_125,
  input  logic             rst_125,
  input  logic             uart_mon_tx_en,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       parity_mode,
  input  logic             stop_bits,
  output logic             uart_tx_fifo_rden,
  input  logic [31:0]      uart_tx_fifo_data,
  input  logic             uart_tx_fifo_empty,
  output logic             uart_txd,
  output logic             tx_busy,
  output logic             tx_word_done
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;
  state_t            state, nxt;
  logic [DIV_W-1:0]  bit_cnt, div_q, eff_div;
  logic [2:0]        bit_idx;
  logic [1:0]        byte_idx, par_q;
  logic              stop_idx, stop_q;
  logic [31:0]       shreg;
  logic              bit_last, par_en, stop_done, last_byte, txd_nxt;
  assign eff_div           = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
  assign bit_last          = bit_cnt == div_q - DIV_W'(1);
  assign par_en            = ^par_q;
  assign stop_done         = bit_last && (stop_idx == stop_q);
  assign last_byte         = byte_idx == 2'd3;
  assign tx_busy           = state != IDLE;
  assign uart_tx_fifo_rden = state == FETCH && !rst_125;
  assign txd_nxt = state == START  ? 1'b0 :
                   state == DATA   ? shreg[bit_idx] :
                   state == PARITY ? (par_q == 2'b10 ? ^shreg[7:0] : ~^shreg[7:0]) :
                   1'b1;
  // state register, bit timing counters, shift register and registered serial output
  always_ff @(posedge clk_125)
    if (rst_125) begin
      state        <= IDLE;
      uart_txd     <= 1'b1;
      tx_word_done <= 1'b0;
      bit_cnt      <= '0;
      bit_idx      <= '0;
      byte_idx     <= '0;
      stop_idx     <= 1'b0;
      shreg        <= '0;
      div_q        <= DIV_W'(RESET_DIV);
      par_q        <= '0;
      stop_q       <= 1'b0;
    end else begin
      state        <= nxt;
      uart_txd     <= txd_nxt;
      tx_word_done <= state == STOP && stop_done && last_byte;
      bit_cnt      <= (state inside {START, DATA, PARITY, STOP}) && !bit_last ? bit_cnt + DIV_W'(1) : '0;
      bit_idx      <= state != DATA ? 3'd0 : bit_idx + 3'(bit_last);
      stop_idx     <= state == STOP && (bit_last ? !stop_done : stop_idx);
      if (state == LOAD) begin
        shreg    <= uart_tx_fifo_data;
        div_q    <= eff_div;
        par_q    <= parity_mode;
        stop_q   <= stop_bits;
        byte_idx <= '0;
      end else if (state == STOP && stop_done && !last_byte) begin
        shreg    <= shreg >> 8;
        byte_idx <= byte_idx + 2'd1;
      end
    end
  // next-state logic; a word's bytes run back to back, IDLE is only revisited between words
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = uart_mon_tx_en && !uart_tx_fifo_empty ? FETCH : IDLE;
      FETCH:   nxt = LOAD;
      LOAD:    nxt = START;
      START:   nxt = bit_last ? DATA : START;
      DATA:    nxt = bit_last && bit_idx == 3'd7 ? (par_en ? PARITY : STOP) : DATA;
      PARITY:  nxt = bit_last ? STOP : PARITY;
      STOP:    nxt = stop_done ? (last_byte ? IDLE : START) : STOP;
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed checks of framing, parity, stop bits, pacing and reset behaviour
module tb_uart_tx_serializer;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, sb = 1'b0;
  logic [15:0] div = 16'd4;
  logic [1:0]  par = 2'b00;
  logic [31:0] data = '0;
  logic        rden, empty, txd, busy, done;
  logic [31:0] mem [32];
  int wr_ptr = 0, rd_ptr = 0, cyc = 0;
  int rden_cyc = 0, rden_cnt = 0, bad_rden = 0, done_cnt = 0;
  int start_cyc = 0, done_cyc = 0, base = 0;
  int checks = 0, failures = 0;
  logic found, hi;

  assign empty = wr_ptr == rd_ptr;
  always #4 clk = ~clk;

  uart_tx_serializer #(.DIV_W(16), .RESET_DIV(1085)) dut (
    .clk_125(clk), .rst_125(rst), .uart_mon_tx_en(en), .baud_div(div),
    .parity_mode(par), .stop_bits(sb), .uart_tx_fifo_rden(rden),
    .uart_tx_fifo_data(data), .uart_tx_fifo_empty(empty),
    .uart_txd(txd), .tx_busy(busy), .tx_word_done(done)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rden) begin
      data   <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    if (rden) begin
      rden_cyc = cyc;
      rden_cnt++;
      if (empty) bad_rden++;
    end
    if (done) done_cnt++;
  end

  task automatic push(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input logic [31:0] w, input int d, input int pm, input int ns,
                            input int gap, input int at_byte, input int act, input string tag);
    logic [11:0] bits;
    logic [7:0]  b;
    logic        ok, seen;
    int          n;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      seen = txd === 1'b0;
    end
    chk({tag, " start"}, seen, 1);
    if (!seen) return;
    start_cyc = cyc;
    chk({tag, " latency"}, start_cyc - rden_cyc, 3);
    if (gap >= 0) chk({tag, " gap"}, start_cyc - done_cyc, gap);
    for (int k = 0; k < 4; k++) begin
      b = w[8*k +: 8];
      if (k == at_byte) begin
        if (act == 1) en = 1'b0;
        else div = 16'd8;
      end
      bits = '1;
      bits[0] = 1'b0;
      bits[8:1] = b;
      n = 9;
      if (pm == 1 || pm == 2) begin
        bits[9] = (pm == 2) ? ^b : ~^b;
        n = 10;
      end
      n += ns;
      ok = 1'b1;
      for (int i = 0; i < n; i++)
        for (int j = 0; j < d; j++) begin
          if (k > 0 || i > 0 || j > 0) @(negedge clk);
          if (txd !== bits[i]) ok = 1'b0;
        end
      chk($sformatf("%s byte%0d", tag, k), ok, 1);
    end
    done_cyc = cyc;
    chk({tag, " done"}, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset txd", txd, 1);
    chk("reset rden", rden, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    // one word, 4 cycles/bit, no parity, one stop bit
    push(32'h44332211);
    en = 1'b1;
    check_word(32'h44332211, 4, 0, 1, -1, -1, 0, "t1");
    chk("t1 busy after", busy, 0);
    repeat (30) @(negedge clk);
    chk("t1 rden count", rden_cnt, 1);
    chk("t1 done count", done_cnt, 1);
    // even then odd parity on 0x00000007
    div = 16'd2;
    par = 2'b10;
    push(32'h00000007);
    check_word(32'h00000007, 2, 2, 1, -1, -1, 0, "t2 even");
    par = 2'b01;
    push(32'h00000007);
    check_word(32'h00000007, 2, 1, 1, -1, -1, 0, "t2 odd");
    // two stop bits at divisor 3, then divisors 0 and 1 clamp to 2
    par = 2'b00;
    div = 16'd3;
    sb = 1'b1;
    push(32'hA5C3F00F);
    check_word(32'hA5C3F00F, 3, 0, 2, -1, -1, 0, "t3 div3");
    sb = 1'b0;
    div = 16'd0;
    push(32'h8001FE7E);
    check_word(32'h8001FE7E, 2, 0, 1, -1, -1, 0, "t3 div0");
    div = 16'd1;
    push(32'h0F0F55AA);
    check_word(32'h0F0F55AA, 2, 0, 1, -1, -1, 0, "t3 div1");
    // three queued words, enable dropped during byte 1 of word 2
    div = 16'd2;
    base = rden_cnt;
    push(32'hDEADBEEF);
    push(32'h01234567);
    push(32'hCAFEF00D);
    check_word(32'hDEADBEEF, 2, 0, 1, -1, -1, 0, "t4 w1");
    check_word(32'h01234567, 2, 0, 1, 4, 1, 1, "t4 w2");
    repeat (100) @(negedge clk);
    chk("t4 rden count", rden_cnt - base, 2);
    chk("t4 word3 kept", empty, 0);
    wr_ptr = rd_ptr;
    // reset during DATA of byte 2
    div = 16'd4;
    en = 1'b1;
    push(32'h12345678);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = txd === 1'b0;
    end
    chk("t5 start", found, 1);
    repeat (89) @(negedge clk);
    chk("t5 busy mid", busy, 1);
    chk("t5 byte2 bit1", txd, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t5 rst txd", txd, 1);
    chk("t5 rst busy", busy, 0);
    chk("t5 rst rden", rden, 0);
    @(negedge clk);
    rst = 1'b0;
    base = rden_cnt;
    hi = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      hi &= txd;
    end
    chk("t5 line high", hi, 1);
    chk("t5 no rden", rden_cnt - base, 0);
    // divisor change mid-word applies to the following word only
    push(32'h87654321);
    push(32'h55AA33CC);
    check_word(32'h87654321, 4, 0, 1, -1, 1, 2, "t6 w1");
    check_word(32'h55AA33CC, 8, 0, 1, 4, -1, 0, "t6 w2");
    repeat (20) @(negedge clk);
    chk("rden while empty", bad_rden, 0);
    chk("total done pulses", done_cnt, 10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
